poly_synth: RTL and testbench



---
 rtl/poly_synth.sv | 181 ++++++++++++++++++
 tb/tb_poly_synth.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_synth.sv
// Multi-voice oscillator bank with per-voice waveform and linear attack/release envelope.
// Voices are mixed, scaled by a master amplitude and also sent out as a first-order PDM bitstream.
module poly_synth #(
    parameter int CLKSPEED    = 48_000_000,
    parameter int SAMPLE_RATE = 48_000,
    parameter int VOICES      = 4,
    parameter int DW          = 10,
    parameter int ACC_W       = 24,
    localparam int VW         = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [VW-1:0]     wr_voice,
    input  logic [1:0]        wr_addr,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic [VOICES-1:0] gate,
    input  logic [DW-1:0]     amp_in,
    output logic              sample_tick,
    output logic [DW-1:0]     mix_out,
    output logic              dout
);

    localparam int DIV  = CLKSPEED / SAMPLE_RATE;
    localparam int CW   = $clog2(DIV);
    localparam int LOGV = $clog2(VOICES);
    localparam int SW   = DW + LOGV;
    localparam int PW   = 2 * DW;

    logic [CW-1:0]    r_tick_cnt;
    logic             w_tick;

    logic [ACC_W-1:0] r_tune  [VOICES];
    logic [1:0]       r_wave  [VOICES];
    logic [DW-1:0]    r_att   [VOICES];
    logic [DW-1:0]    r_rel   [VOICES];

    logic [ACC_W-1:0] r_phase [VOICES];
    logic [DW-1:0]    r_env   [VOICES];
    logic [15:0]      r_lfsr  [VOICES];

    logic [DW:0]      w_env_up  [VOICES];
    logic [DW-1:0]    w_env_nxt [VOICES];
    logic [DW-1:0]    w_p       [VOICES];
    logic [DW-1:0]    w_wave    [VOICES];
    logic [PW-1:0]    w_vprod   [VOICES];

    logic             r_s2_en;
    logic             r_s3_en;
    logic [DW-1:0]    r_voice [VOICES];
    logic [SW-1:0]    w_sum;
    logic [DW-1:0]    w_avg;
    logic [PW-1:0]    w_mprod;
    logic [DW-1:0]    r_mix;

    logic [DW-1:0]    r_err;
    logic             r_dout;
    logic [DW:0]      w_pdm_sum;

    assign w_tick      = (r_tick_cnt == CW'(DIV - 1));
    assign sample_tick = w_tick;
    assign mix_out     = r_mix;
    assign dout        = r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
        end
    end

    // Writes land immediately; a write on a tick edge is only seen by the following tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                r_tune[i] <= '0;
                r_wave[i] <= '0;
                r_att[i]  <= '0;
                r_rel[i]  <= '0;
            end
        end else if (wr_en && (int'(wr_voice) < VOICES)) begin
            case (wr_addr)
                2'd0: r_tune[wr_voice] <= wr_data;
                2'd1: r_wave[wr_voice] <= wr_data[1:0];
                2'd2: r_att[wr_voice]  <= wr_data[DW-1:0];
                2'd3: r_rel[wr_voice]  <= wr_data[DW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_env_up[i]  = {1'b0, r_env[i]} + {1'b0, r_att[i]};
            w_env_nxt[i] = r_env[i];
            if (gate[i]) begin
                w_env_nxt[i] = w_env_up[i][DW] ? '1 : w_env_up[i][DW-1:0];
            end else begin
                w_env_nxt[i] = (r_env[i] > r_rel[i]) ? (r_env[i] - r_rel[i]) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                r_phase[i] <= '0;
                r_env[i]   <= '0;
                r_lfsr[i]  <= 16'hACE1 ^ 16'(i);
            end
        end else if (w_tick) begin
            for (int i = 0; i < VOICES; i++) begin
                r_phase[i] <= r_phase[i] + r_tune[i];
                r_env[i]   <= w_env_nxt[i];
                r_lfsr[i]  <= {1'b0, r_lfsr[i][15:1]} ^ (r_lfsr[i][0] ? 16'hB400 : 16'h0000);
            end
        end
    end

    // Noise taps the top DW bits of the LFSR, so DW must not exceed 16.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_p[i]    = r_phase[i][ACC_W-1 -: DW];
            w_wave[i] = w_p[i];
            case (r_wave[i])
                2'd0: w_wave[i] = w_p[i];
                2'd1: w_wave[i] = {DW{w_p[i][DW-1]}};
                2'd2: w_wave[i] = {(w_p[i][DW-1] ? ~w_p[i][DW-2:0] : w_p[i][DW-2:0]), 1'b0};
                2'd3: w_wave[i] = r_lfsr[i][15 -: DW];
                default: w_wave[i] = w_p[i];
            endcase
            w_vprod[i] = PW'(w_wave[i]) * PW'(r_env[i]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            w_sum = w_sum + SW'(r_voice[i]);
        end
        w_avg   = DW'(w_sum >> LOGV);
        w_mprod = PW'(w_avg) * PW'(amp_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_en <= 1'b0;
            r_s3_en <= 1'b0;
            r_mix   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_voice[i] <= '0;
            end
        end else begin
            r_s2_en <= w_tick;
            r_s3_en <= r_s2_en;
            if (r_s2_en) begin
                for (int i = 0; i < VOICES; i++) begin
                    r_voice[i] <= DW'(w_vprod[i] >> DW);
                end
            end
            if (r_s3_en) begin
                r_mix <= DW'(w_mprod >> DW);
            end
        end
    end

    assign w_pdm_sum = {1'b0, r_err} + {1'b0, r_mix};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= '0;
            r_dout <= 1'b0;
        end else begin
            {r_dout, r_err} <= w_pdm_sum;
        end
    end

endmodule

// File: tb/tb_poly_synth.sv
// Directed bench for poly_synth: tick timing, saw/square mixing, envelope ramps,
// tick-coincident tuning writes, PDM density and mid-note reset.
module tb_poly_synth;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_voice;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [3:0]  gate;
    logic [9:0]  amp_in;
    logic        sample_tick;
    logic [9:0]  mix_out;
    logic        dout;

    int checks   = 0;
    int failures = 0;

    poly_synth #(
        .CLKSPEED(1000), .SAMPLE_RATE(100), .VOICES(4), .DW(10), .ACC_W(24)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_voice(wr_voice), .wr_addr(wr_addr),
        .wr_data(wr_data), .gate(gate), .amp_in(amp_in), .sample_tick(sample_tick),
        .mix_out(mix_out), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        gate  = '0;
        amp_in = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] v, input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_voice = v; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Leaves the bench sampling inside the tick cycle (before the tick edge).
    task automatic wait_tick();
        int n = 0;
        while (sample_tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(sample_tick), 32'd1);
    endtask

    initial begin
        int ones;
        rst = 1'b1; wr_en = 1'b0; wr_voice = '0; wr_addr = '0; wr_data = '0;
        gate = '0; amp_in = '0;

        // 1: reset values and tick cadence, cycle 0 = first cycle with rst low
        do_reset();
        chk("rst_mix", 32'(mix_out), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_lfsr1", 32'(dut.r_lfsr[1]), 32'hACE0);
        for (int c = 0; c < 30; c++) begin
            chk("tick_cadence", 32'(sample_tick), 32'((c % 10) == 9));
            chk("idle_mix", 32'(mix_out), 32'd0);
            step();
        end
        chk("idle_dout", 32'(dout), 32'd0);

        // 2: saw on voice 0, p steps 64 per tick; after 8 ticks p=512, env=1023
        //    voice=(512*1023)>>10=511, 511>>2=127, (127*1023)>>10=126
        do_reset();
        wr(2'd0, 2'd0, 24'h100000);
        wr(2'd0, 2'd1, 24'd0);
        wr(2'd0, 2'd2, 24'd1023);
        gate = 4'b0001; amp_in = 10'd1023;
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            step();
        end
        chk("saw_phase8", 32'(dut.r_phase[0]), 32'h800000);
        chk("saw_env8", 32'(dut.r_env[0]), 32'd1023);
        step();
        step();
        chk("saw_mix8", 32'(mix_out), 32'd126);

        // 3: attack 100 ramps to clamp, release 300 falls to 0 and holds
        do_reset();
        wr(2'd0, 2'd2, 24'd100);
        gate = 4'b0001;
        for (int k = 1; k <= 11; k++) begin
            wait_tick();
            step();
            chk("env_attack", 32'(dut.r_env[0]), (k * 100 > 1023) ? 32'd1023 : 32'(k * 100));
        end
        wr(2'd0, 2'd3, 24'd300);
        gate = 4'b0000;
        wait_tick(); step(); chk("env_rel1", 32'(dut.r_env[0]), 32'd723);
        wait_tick(); step(); chk("env_rel2", 32'(dut.r_env[0]), 32'd423);
        wait_tick(); step(); chk("env_rel3", 32'(dut.r_env[0]), 32'd123);
        wait_tick(); step(); chk("env_rel4", 32'(dut.r_env[0]), 32'd0);
        wait_tick(); step(); chk("env_rel5", 32'(dut.r_env[0]), 32'd0);

        // 4: square m=1, env 1023, amp 1023: voice=(1023*1023)>>10=1022, 1022>>2=255,
        //    (255*1023)>>10=254; PDM density over 1024 cycles is 254 ones
        do_reset();
        wr(2'd0, 2'd1, 24'd1);
        wr(2'd0, 2'd2, 24'd1023);
        wr(2'd0, 2'd0, 24'h800000);
        gate = 4'b0001; amp_in = 10'd1023;
        wait_tick();
        step();
        wr(2'd0, 2'd0, 24'h000000);
        step();
        chk("sq_hi_mix", 32'(mix_out), 32'd254);
        ones = 0;
        for (int c = 0; c < 1024; c++) begin
            step();
            ones += int'(dout);
        end
        chk("sq_hi_ones_in_range", 32'((ones >= 253) && (ones <= 255)), 32'd1);
        chk("sq_hi_mix_steady", 32'(mix_out), 32'd254);
        wr(2'd0, 2'd0, 24'h800000);
        wait_tick();
        step();
        wr(2'd0, 2'd0, 24'h000000);
        step();
        chk("sq_lo_phase", 32'(dut.r_phase[0]), 32'd0);
        chk("sq_lo_mix", 32'(mix_out), 32'd0);
        step();
        ones = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            ones += int'(dout);
        end
        chk("sq_lo_ones", 32'(ones), 32'd0);

        // 5: tuning write on the tick edge; that tick uses the old word
        do_reset();
        wr(2'd0, 2'd0, 24'h040000);
        wait_tick();
        step();
        chk("tw_phase1", 32'(dut.r_phase[0]), 32'h040000);
        wait_tick();
        wr(2'd0, 2'd0, 24'h100000);
        chk("tw_phase2_old", 32'(dut.r_phase[0]), 32'h080000);
        chk("tw_tune_new", 32'(dut.r_tune[0]), 32'h100000);
        wait_tick();
        step();
        chk("tw_phase3_new", 32'(dut.r_phase[0]), 32'h180000);

        // 6: mid-note reset; saw after 3 ticks: p=192 -> 191 -> 47 -> 46
        do_reset();
        wr(2'd0, 2'd0, 24'h100000);
        wr(2'd0, 2'd1, 24'd0);
        wr(2'd0, 2'd2, 24'd1023);
        gate = 4'b0001; amp_in = 10'd1023;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            step();
        end
        step();
        step();
        chk("note_mix3", 32'(mix_out), 32'd46);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_mix", 32'(mix_out), 32'd0);
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_env", 32'(dut.r_env[0]), 32'd0);
        chk("mrst_phase", 32'(dut.r_phase[0]), 32'd0);
        chk("mrst_tune", 32'(dut.r_tune[0]), 32'd0);
        chk("mrst_tick", 32'(sample_tick), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            step();
            chk("mrst_tick_restart", 32'(sample_tick), 32'(c == 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
